// File: rtl/ntm_matrix_vector_product.sv
// Streaming signed matrix-vector product y = A*x: row-major operand pairs in, one y[i] per row out.
// Build option NTM_MATRIX_VECTOR_PRODUCT_SATURATE_EN clamps each row result instead of wrapping it.
module ntm_matrix_vector_product #(
  parameter int DATA_SIZE  = 16,
  parameter int INDEX_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INDEX_SIZE-1:0] size_i_in,
  input  logic [INDEX_SIZE-1:0] size_j_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_SIZE-1:0]  data_a_in,
  input  logic [DATA_SIZE-1:0]  data_b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_SIZE-1:0]  data_out,
  output logic                  ready
);

  localparam int PROD_W = 2 * DATA_SIZE;
  localparam int ACC_W  = PROD_W + INDEX_SIZE;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [INDEX_SIZE-1:0] IDX_ZERO = '0;
  localparam logic [INDEX_SIZE-1:0] IDX_ONE  = {{(INDEX_SIZE-1){1'b0}}, 1'b1};

  logic [1:0]              state_q, state_d;
  logic [INDEX_SIZE-1:0]   size_i_q, size_i_d;
  logic [INDEX_SIZE-1:0]   size_j_q, size_j_d;
  logic [INDEX_SIZE-1:0]   row_q, row_d;
  logic [INDEX_SIZE-1:0]   col_q, col_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;

  logic signed [PROD_W-1:0] a_ext, b_ext, prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [DATA_SIZE-1:0]     res;

  // Operands are sign-extended first so the product is the full-width signed result.
  assign a_ext   = {{DATA_SIZE{data_a_in[DATA_SIZE-1]}}, data_a_in};
  assign b_ext   = {{DATA_SIZE{data_b_in[DATA_SIZE-1]}}, data_b_in};
  assign prod    = a_ext * b_ext;
  assign acc_sum = acc_q + {{INDEX_SIZE{prod[PROD_W-1]}}, prod};

`ifdef NTM_MATRIX_VECTOR_PRODUCT_SATURATE_EN
  localparam logic signed [ACC_W-1:0] RES_MAX =
    {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN =
    {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  always_comb begin
    res = acc_sum[DATA_SIZE-1:0];
    if (acc_sum > RES_MAX) begin
      res = {1'b0, {(DATA_SIZE-1){1'b1}}};
    end else if (acc_sum < RES_MIN) begin
      res = {1'b1, {(DATA_SIZE-1){1'b0}}};
    end
  end
`else
  assign res = acc_sum[DATA_SIZE-1:0];
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    size_i_d = size_i_q;
    size_j_d = size_j_q;
    row_d    = row_q;
    col_d    = col_q;
    acc_d    = acc_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          size_i_d = size_i_in;
          size_j_d = size_j_in;
          row_d    = '0;
          col_d    = '0;
          acc_d    = '0;
          state_d  = (size_i_in == IDX_ZERO || size_j_in == IDX_ZERO) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_sum;
          col_d = col_q + IDX_ONE;
          if (col_q == size_j_q - IDX_ONE) begin
            data_d  = res;
            state_d = S_OUTPUT;
          end
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (row_q == size_i_q - IDX_ONE) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + IDX_ONE;
            col_d   = '0;
            acc_d   = '0;
            state_d = S_ACCUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      size_i_q <= '0;
      size_j_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      acc_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      size_i_q <= size_i_d;
      size_j_q <= size_j_d;
      row_q    <= row_d;
      col_q    <= col_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUTPUT);
  assign ready     = (state_q == S_DONE);
  assign data_out  = data_q;

endmodule

// File: tb/tb_ntm_matrix_vector_product.sv
// Scoreboard bench for ntm_matrix_vector_product: a 16-bit instance for the product/handshake
// cases and an 8-bit instance for the overflow case, each with its own expected-result queue.
module tb_ntm_matrix_vector_product;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-bit instance
  logic               start;
  logic [7:0]         size_i_in, size_j_in;
  logic               in_valid, in_ready;
  logic signed [15:0] data_a_in, data_b_in;
  logic               out_valid, out_ready;
  logic [15:0]        data_out;
  logic               ready;

  // 8-bit instance
  logic              s8_start;
  logic [7:0]        s8_size_i, s8_size_j;
  logic              s8_in_valid, s8_in_ready;
  logic signed [7:0] s8_a, s8_b;
  logic              s8_out_valid, s8_out_ready;
  logic [7:0]        s8_data_out;
  logic              s8_ready;

  ntm_matrix_vector_product #(.DATA_SIZE(16), .INDEX_SIZE(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .size_i_in(size_i_in), .size_j_in(size_j_in),
    .in_valid(in_valid), .in_ready(in_ready), .data_a_in(data_a_in), .data_b_in(data_b_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .ready(ready)
  );

  ntm_matrix_vector_product #(.DATA_SIZE(8), .INDEX_SIZE(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .size_i_in(s8_size_i), .size_j_in(s8_size_j),
    .in_valid(s8_in_valid), .in_ready(s8_in_ready), .data_a_in(s8_a), .data_b_in(s8_b),
    .out_valid(s8_out_valid), .out_ready(s8_out_ready), .data_out(s8_data_out), .ready(s8_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc;
  longint exp_q[$];
  longint exp8_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitors: compare on the cycle an output handshake is presented.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output16", $signed(data_out), 0);
      else check("data_out16", $signed(data_out), exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && s8_out_valid && s8_out_ready) begin
      if (exp8_q.size() == 0) check("unexpected_output8", $signed(s8_data_out), 0);
      else check("data_out8", $signed(s8_data_out), exp8_q.pop_front());
    end
  end

  // Cycle 1 is the cycle in which start is high.
  task automatic do_start(input logic [7:0] i, input logic [7:0] j);
    @(posedge clk); #1;
    start = 1'b1; size_i_in = i; size_j_in = j;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pair(input logic signed [15:0] a, input logic signed [15:0] b);
    int n = 0;
    in_valid = 1'b1; data_a_in = a; data_b_in = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_pair_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string name, input int exp_cycle);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 100);
    if (!ready) check({name, "_ready_timeout"}, 0, 1);
    else begin
      check({name, "_ready_cycle"}, cyc - start_cyc + 1, exp_cycle);
      @(negedge clk);
      check({name, "_ready_single_pulse"}, ready, 0);
    end
  endtask

  task automatic basic_stream();
    send_pair(1, 5);
    send_pair(2, 6);
    send_pair(3, 5);
    send_pair(4, 6);
    in_valid = 1'b0;
  endtask

  task automatic run8(input logic signed [7:0] a, input logic signed [7:0] b, input longint exp);
    int n = 0;
    exp8_q.push_back(exp);
    @(posedge clk); #1;
    s8_start = 1'b1; s8_size_i = 8'd1; s8_size_j = 8'd1;
    @(posedge clk); #1;
    s8_start = 1'b0; s8_in_valid = 1'b1; s8_a = a; s8_b = b;
    @(negedge clk);
    while (!s8_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s8_in_ready) check("run8_in_timeout", 0, 1);
    @(posedge clk); #1;
    s8_in_valid = 1'b0;
    n = 0;
    while (exp8_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bit held_ok;
    bit idle_ok;
    int ready_at;
    rst = 1'b1;
    start = 1'b0; size_i_in = '0; size_j_in = '0;
    in_valid = 1'b0; data_a_in = '0; data_b_in = '0; out_ready = 1'b1;
    s8_start = 1'b0; s8_size_i = '0; s8_size_j = '0;
    s8_in_valid = 1'b0; s8_a = '0; s8_b = '0; s8_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_ready", ready, 0);
    check("rst8_in_ready", s8_in_ready, 0);
    check("rst8_out_valid", s8_out_valid, 0);
    check("rst8_data_out", s8_data_out, 0);
    check("rst8_ready", s8_ready, 0);

    // Basic: [[1,2],[3,4]] * [5,6] = [17,39]
    exp_q.push_back(17);
    exp_q.push_back(39);
    do_start(2, 2);
    basic_stream();
    wait_ready("basic", 8);

    // Backpressure: out_ready low for 3 cycles on row 0
    exp_q.push_back(17);
    exp_q.push_back(39);
    out_ready = 1'b0;
    do_start(2, 2);
    send_pair(1, 5);
    send_pair(2, 6);
    fork
      begin
        held_ok = 1'b1;
        repeat (3) begin
          @(negedge clk);
          if (!out_valid || $signed(data_out) != 17 || in_ready) held_ok = 1'b0;
          @(posedge clk); #1;
        end
        check("stall_held_valid_data_no_ready", held_ok, 1);
        out_ready = 1'b1;
      end
      begin
        send_pair(3, 5);
        send_pair(4, 6);
        in_valid = 1'b0;
      end
    join
    wait_ready("stall", 0 + (cyc - start_cyc + 1) * 0 + 11);

    // Zero size: I=0, J=3, in_valid driven but must be ignored
    do_start(0, 3);
    ready_at = -1;
    idle_ok  = 1'b1;
    in_valid = 1'b1; data_a_in = 16'sd9; data_b_in = 16'sd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ready && ready_at < 0) ready_at = cyc - start_cyc + 1;
      if (in_ready || out_valid) idle_ok = 1'b0;
    end
    in_valid = 1'b0;
    check("zero_ready_cycle", ready_at, 2);
    check("zero_no_in_ready_no_out_valid", idle_ok, 1);

    // Reset mid-row, then rerun the basic vectors
    do_start(2, 2);
    send_pair(7, 7);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    exp_q.push_back(17);
    exp_q.push_back(39);
    do_start(2, 2);
    basic_stream();
    wait_ready("midrst_rerun", 8);

    // Start with I=5 while busy: ignored
    exp_q.push_back(17);
    exp_q.push_back(39);
    do_start(2, 2);
    send_pair(1, 5);
    start = 1'b1; size_i_in = 8'd5;
    send_pair(2, 6);
    start = 1'b0;
    send_pair(3, 5);
    send_pair(4, 6);
    in_valid = 1'b0;
    wait_ready("busy_start", 8);
    repeat (4) @(negedge clk);
    check("busy_start_idle_after", out_valid, 0);

    // Negative result: [-3,7,-2] . [4,-5,-8] = -31
    exp_q.push_back(-31);
    do_start(1, 3);
    send_pair(-3, 4);
    send_pair(7, -5);
    send_pair(-2, -8);
    in_valid = 1'b0;
    wait_ready("negative", 6);

    // Overflow on the 8-bit instance: 100*100 = 10000, -100*100 = -10000
`ifdef NTM_MATRIX_VECTOR_PRODUCT_SATURATE_EN
    run8(8'sd100, 8'sd100, 127);
    run8(-8'sd100, 8'sd100, -128);
`else
    run8(8'sd100, 8'sd100, 16);
    run8(-8'sd100, 8'sd100, -16);
`endif

    repeat (3) @(negedge clk);
    check("queue16_drained", exp_q.size(), 0);
    check("queue8_drained", exp8_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ntm_matrix_vector_product.md
# ntm_matrix_vector_product

Streaming signed matrix-vector product y = A·x. It sits directly downstream of the matrix transpose stage in the NTM algebra chain and consumes its element stream. Operand pairs (a[i][j], x[j]) arrive row-major over a valid/ready handshake and are multiply-accumulated per row. Each completed row result y[i] is emitted over a second valid/ready handshake.

## Interface
- DATA_SIZE, 16: signed width of operands and result.
- INDEX_SIZE, 8: width of the size inputs and the internal row/column counters.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; honoured only in IDLE.
- size_i_in  input  INDEX_SIZE  row count I; latched on accepted start.
- size_j_in  input  INDEX_SIZE  column count J; latched on accepted start.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts pair.
- data_a_in  input  DATA_SIZE  matrix element a[i][j], signed.
- data_b_in  input  DATA_SIZE  vector element x[j], signed.
- out_valid  output  1  data_out holds y[i].
- out_ready  input  1  consumer accepts data_out.
- data_out  output  DATA_SIZE  row result y[i].
- ready  output  1  one-cycle pulse when the product is complete.

## Operation
- FSM states: IDLE, ACCUM, OUTPUT, DONE.
- IDLE, start=1:
  - latch I and J; clear accumulator, row and column counters.
  - If I=0 or J=0, go to DONE (no outputs). Otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready: acc += a*b. Product is full 2*DATA_SIZE signed. Accumulator is 2*DATA_SIZE+INDEX_SIZE signed and never overflows.
  - The column counter increments on each accepted pair. On the J-th pair, go to OUTPUT.
- OUTPUT:
  - out_valid=1 and data_out=result(acc), both held stable until out_ready.
  - On handshake with row=I-1: go to DONE.
  - On handshake otherwise: row++, clear acc and column counter, return to ACCUM.
- DONE: ready=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE. in_valid is ignored outside ACCUM.
- rst in any state: return to IDLE, clear all counters and the accumulator, drop any partial row. The first cycle after rst deasserts behaves as IDLE.

## Timing
- Reset values: in_ready=0, out_valid=0, data_out=0, ready=0.
- IDLE→ACCUM: in_ready=1 in the cycle after the start edge.
- ACCUM sustains one pair per cycle with no bubbles.
- Last pair of a row accepted at edge t: out_valid=1 from t+1.
- Output handshake at edge t:
  - If more rows remain, in_ready=1 from t+1.
  - On the last row, ready=1 for the cycle after t only.
- Minimum run time, no stalls: I·(J+1)+2 cycles from the start edge to the ready pulse.
- data_out is registered and changes only on OUTPUT entry. It holds its last value in IDLE and DONE.

## Configuration
- Macro NTM_MATRIX_VECTOR_PRODUCT_SATURATE_EN.
- Defined: result(acc) clamps to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
- Undefined: result(acc) is the low DATA_SIZE bits of acc (two's-complement wrap).
- Handshake and timing are identical in both builds.

## Test plan
- Basic product, DATA_SIZE=16: I=2, J=2, A=[[1,2],[3,4]], x=[5,6], no stalls.
  - Expect data_out 17 then 39.
  - ready pulse at cycle 8 after the start edge.
- Backpressure: same as the basic test, with out_ready low for 3 cycles on row 0.
  - out_valid and data_out=17 held for those 3 cycles.
  - in_ready=0 throughout the stall; no pair is lost.
- Overflow, DATA_SIZE=8: I=1, J=1, pair (100,100).
  - With macro: data_out=127.
  - Without macro: data_out=16.
  - Negative case (-100,100), with macro: data_out=-128.
- Zero size: start with I=0, J=3.
  - out_valid never asserted; in_ready stays 0.
  - ready pulses in the cycle after the start edge.
- Reset mid-row: rst during ACCUM after 1 of 2 pairs, then restart with the basic vectors.
  - Outputs are 17 and 39, with no residue from the aborted row.
- Start while busy: pulse start with I=5 during ACCUM of the basic run.
  - Ignored; exactly 2 outputs, then ready.
